// File: rtl/tdd_multiwin_pkg.sv
// Shared types and helpers for the multi-window TDD timing engine.
package tdd_multiwin_pkg;

    localparam int unsigned STATE_WIDTH = 2;

    typedef enum logic [STATE_WIDTH-1:0] {
        IDLE    = 2'b00,
        ARMED   = 2'b01,
        WAITING = 2'b10,
        RUNNING = 2'b11
    } state_t;

    // LSB of window w of channel ch inside a flat win_on/win_off vector.
    function automatic int unsigned win_lsb(input int unsigned ch,
                                            input int unsigned w,
                                            input int unsigned window_count,
                                            input int unsigned reg_width);
        return (ch * window_count + w) * reg_width;
    endfunction

endpackage

// File: rtl/tdd_multiwin_channel.sv
// One TDD output channel: WINDOW_COUNT window flops plus the registered output.
module tdd_multiwin_channel
    import tdd_multiwin_pkg::*;
#(
    parameter int unsigned WINDOW_COUNT   = 2,
    parameter int unsigned REGISTER_WIDTH = 32,
    parameter logic        DEFAULT_LEVEL  = 1'b0
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   run,
    input  logic [REGISTER_WIDTH-1:0]              counter,
    input  logic [WINDOW_COUNT*REGISTER_WIDTH-1:0] win_on,
    input  logic [WINDOW_COUNT*REGISTER_WIDTH-1:0] win_off,
    input  logic                                   en_next,
    input  logic                                   pol_next,
    output logic                                   channel
);

    logic [WINDOW_COUNT-1:0] win_q;
    logic [WINDOW_COUNT-1:0] win_d;
    logic                    channel_d;

    // Clear has priority over set, so on == off never opens a window.
    always_comb begin
        win_d = win_q;
        for (int unsigned w = 0; w < WINDOW_COUNT; w++) begin
            if (!run) begin
                win_d[w] = 1'b0;
            end else if (counter == win_off[win_lsb(0, w, WINDOW_COUNT, REGISTER_WIDTH) +: REGISTER_WIDTH]) begin
                win_d[w] = 1'b0;
            end else if (counter == win_on[win_lsb(0, w, WINDOW_COUNT, REGISTER_WIDTH) +: REGISTER_WIDTH]) begin
                win_d[w] = 1'b1;
            end
        end
    end

    // Output follows the next window state so a match at N shows at N+1.
    always_comb begin
        channel_d = pol_next;
        if (en_next) begin
            channel_d = (|win_d) ^ pol_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_q   <= '0;
            channel <= DEFAULT_LEVEL;
        end else begin
            win_q   <= win_d;
            channel <= channel_d;
        end
    end

endmodule

// File: rtl/tdd_multiwin_core.sv
// TDD timing engine: one frame counter driving per-channel multi-window outputs.
// Optional mid-burst resync is enabled by defining TDD_MULTIWIN_RESYNC_EN.
module tdd_multiwin_core
    import tdd_multiwin_pkg::*;
#(
    parameter int unsigned              CHANNEL_COUNT     = 8,
    parameter int unsigned              WINDOW_COUNT      = 2,
    parameter int unsigned              REGISTER_WIDTH    = 32,
    parameter int unsigned              BURST_COUNT_WIDTH = 32,
    parameter logic [CHANNEL_COUNT-1:0] DEFAULT_POLARITY  = '0
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic                                                 enable,
    input  logic                                                 sync,
    input  logic [BURST_COUNT_WIDTH-1:0]                         burst_count,
    input  logic [REGISTER_WIDTH-1:0]                            startup_delay,
    input  logic [REGISTER_WIDTH-1:0]                            frame_length,
    input  logic [CHANNEL_COUNT-1:0]                             ch_en,
    input  logic [CHANNEL_COUNT-1:0]                             ch_pol,
    input  logic [CHANNEL_COUNT*WINDOW_COUNT*REGISTER_WIDTH-1:0] win_on,
    input  logic [CHANNEL_COUNT*WINDOW_COUNT*REGISTER_WIDTH-1:0] win_off,
    output logic [CHANNEL_COUNT-1:0]                             channel,
    output logic                                                 active,
    output logic [STATE_WIDTH-1:0]                               state,
    output logic [REGISTER_WIDTH-1:0]                            counter,
    output logic                                                 endof_frame,
    output logic [BURST_COUNT_WIDTH-1:0]                         frame_index
);

    localparam int unsigned WIN_BITS = CHANNEL_COUNT * WINDOW_COUNT * REGISTER_WIDTH;

    state_t state_q;
    state_t state_d;

    logic [BURST_COUNT_WIDTH-1:0] sh_burst;
    logic [REGISTER_WIDTH-1:0]    sh_delay;
    logic [REGISTER_WIDTH-1:0]    sh_flen;
    logic [CHANNEL_COUNT-1:0]     sh_en;
    logic [CHANNEL_COUNT-1:0]     sh_pol;
    logic [WIN_BITS-1:0]          sh_on;
    logic [WIN_BITS-1:0]          sh_off;

    logic                         accept_c;
    logic                         resync_c;
    logic                         capture_c;
    logic                         last_frame_c;
    logic [REGISTER_WIDTH-1:0]    flen_n_c;
    logic [REGISTER_WIDTH-1:0]    flen_eff_c;
    logic [CHANNEL_COUNT-1:0]     en_n_c;
    logic [CHANNEL_COUNT-1:0]     pol_n_c;
    logic                         run_c;
    logic [REGISTER_WIDTH-1:0]    counter_d;
    logic [BURST_COUNT_WIDTH-1:0] frame_index_d;
    logic                         endof_frame_d;
    logic                         active_d;

    assign accept_c = enable && sync && (state_q == ARMED);
`ifdef TDD_MULTIWIN_RESYNC_EN
    assign resync_c = enable && sync && ((state_q == WAITING) || (state_q == RUNNING));
`else
    assign resync_c = 1'b0;
`endif
    assign capture_c = accept_c || resync_c;

    // Values the shadow registers will hold next cycle.
    assign flen_n_c     = capture_c ? frame_length : sh_flen;
    assign flen_eff_c   = (flen_n_c == '0) ? REGISTER_WIDTH'(1) : flen_n_c;
    assign en_n_c       = capture_c ? ch_en  : sh_en;
    assign pol_n_c      = capture_c ? ch_pol : sh_pol;
    assign last_frame_c = (sh_burst != '0) && (frame_index == sh_burst - BURST_COUNT_WIDTH'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_burst <= '0;
            sh_delay <= '0;
            sh_flen  <= '0;
            sh_en    <= '0;
            sh_pol   <= DEFAULT_POLARITY;
            sh_on    <= '0;
            sh_off   <= '0;
        end else if (capture_c) begin
            sh_burst <= burst_count;
            sh_delay <= startup_delay;
            sh_flen  <= frame_length;
            sh_en    <= ch_en;
            sh_pol   <= ch_pol;
            sh_on    <= win_on;
            sh_off   <= win_off;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; disable outranks any sync.
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = IDLE;
        end else if (capture_c) begin
            state_d = (startup_delay == '0) ? RUNNING : WAITING;
        end else begin
            case (state_q)
                IDLE:    state_d = ARMED;
                ARMED:   state_d = ARMED;
                WAITING: if (counter == sh_delay - REGISTER_WIDTH'(1)) state_d = RUNNING;
                RUNNING: if (endof_frame && last_frame_c) state_d = ARMED;
                default: state_d = IDLE;
            endcase
        end
    end

    // Next values of the registered outputs.
    always_comb begin
        counter_d     = '0;
        frame_index_d = frame_index;
        if ((state_d != state_q) || capture_c) begin
            counter_d = '0;
        end else if (state_q == WAITING) begin
            counter_d = counter + REGISTER_WIDTH'(1);
        end else if (state_q == RUNNING) begin
            counter_d = endof_frame ? '0 : counter + REGISTER_WIDTH'(1);
        end

        if ((state_d == IDLE) || (state_d == ARMED) || capture_c) begin
            frame_index_d = '0;
        end else if ((state_q == RUNNING) && endof_frame) begin
            frame_index_d = frame_index + BURST_COUNT_WIDTH'(1);
        end

        endof_frame_d = (state_d == RUNNING) && (counter_d == flen_eff_c - REGISTER_WIDTH'(1));
        active_d      = (state_d == WAITING) || (state_d == RUNNING);
        run_c         = (state_q == RUNNING) && (state_d == RUNNING) && !capture_c && !endof_frame;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter     <= '0;
            frame_index <= '0;
            endof_frame <= 1'b0;
            active      <= 1'b0;
        end else begin
            counter     <= counter_d;
            frame_index <= frame_index_d;
            endof_frame <= endof_frame_d;
            active      <= active_d;
        end
    end

    assign state = state_q;

    for (genvar i = 0; i < CHANNEL_COUNT; i++) begin : g_ch
        localparam int unsigned LSB = win_lsb(i, 0, WINDOW_COUNT, REGISTER_WIDTH);
        tdd_multiwin_channel #(
            .WINDOW_COUNT  (WINDOW_COUNT),
            .REGISTER_WIDTH(REGISTER_WIDTH),
            .DEFAULT_LEVEL (DEFAULT_POLARITY[i])
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .run     (run_c),
            .counter (counter),
            .win_on  (sh_on[LSB +: WINDOW_COUNT*REGISTER_WIDTH]),
            .win_off (sh_off[LSB +: WINDOW_COUNT*REGISTER_WIDTH]),
            .en_next (en_n_c[i]),
            .pol_next(pol_n_c[i]),
            .channel (channel[i])
        );
    end

endmodule

// File: tb/tb_tdd_multiwin_core.sv
// Directed table-driven bench for tdd_multiwin_core.
module tb_tdd_multiwin_core;

    localparam int unsigned CC = 8;
    localparam int unsigned WC = 2;
    localparam int unsigned RW = 32;
    localparam int unsigned BW = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic              sync;
    logic [BW-1:0]     burst_count;
    logic [RW-1:0]     startup_delay;
    logic [RW-1:0]     frame_length;
    logic [CC-1:0]     ch_en;
    logic [CC-1:0]     ch_pol;
    logic [CC*WC*RW-1:0] win_on;
    logic [CC*WC*RW-1:0] win_off;
    logic [CC-1:0]     channel;
    logic              active;
    logic [1:0]        state;
    logic [RW-1:0]     counter;
    logic              endof_frame;
    logic [BW-1:0]     frame_index;

    tdd_multiwin_core #(
        .CHANNEL_COUNT    (CC),
        .WINDOW_COUNT     (WC),
        .REGISTER_WIDTH   (RW),
        .BURST_COUNT_WIDTH(BW),
        .DEFAULT_POLARITY (8'hA5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .sync         (sync),
        .burst_count  (burst_count),
        .startup_delay(startup_delay),
        .frame_length (frame_length),
        .ch_en        (ch_en),
        .ch_pol       (ch_pol),
        .win_on       (win_on),
        .win_off      (win_off),
        .channel      (channel),
        .active       (active),
        .state        (state),
        .counter      (counter),
        .endof_frame  (endof_frame),
        .frame_index  (frame_index)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          k;
        logic [7:0]  ch;
        logic [1:0]  st;
        logic [31:0] cnt;
        logic        eof;
        logic [31:0] fidx;
        logic        act;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    int cur_k    = 0;

    vec_t tab_a[12];
    vec_t tab_c[8];

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        n_checks++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act_v, exp_v);
        end
    endtask

    task automatic set_win(input int ch, input int w, input logic [31:0] on, input logic [31:0] off);
        win_on[(ch*WC+w)*RW +: RW]  = on;
        win_off[(ch*WC+w)*RW +: RW] = off;
    endtask

    // Pulse sync for one cycle; afterwards the bench sits at cycle T+1.
    task automatic start_sync();
        sync = 1'b1;
        tick();
        sync = 1'b0;
        cur_k = 1;
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        while (cur_k < v.k) begin
            tick();
            cur_k++;
        end
        check($sformatf("%s_k%0d_ch", tag, v.k),   32'(channel),     32'(v.ch));
        check($sformatf("%s_k%0d_st", tag, v.k),   32'(state),       32'(v.st));
        check($sformatf("%s_k%0d_cnt", tag, v.k),  counter,          v.cnt);
        check($sformatf("%s_k%0d_eof", tag, v.k),  32'(endof_frame), 32'(v.eof));
        check($sformatf("%s_k%0d_fidx", tag, v.k), frame_index,      v.fidx);
        check($sformatf("%s_k%0d_act", tag, v.k),  32'(active),      32'(v.act));
    endtask

    initial begin
        // Burst of two 10-cycle frames, ch0 window (2,5).
        tab_a[0]  = '{1,  8'h00, 2'd3, 32'd0, 1'b0, 32'd0, 1'b1};
        tab_a[1]  = '{3,  8'h00, 2'd3, 32'd2, 1'b0, 32'd0, 1'b1};
        tab_a[2]  = '{4,  8'h01, 2'd3, 32'd3, 1'b0, 32'd0, 1'b1};
        tab_a[3]  = '{6,  8'h01, 2'd3, 32'd5, 1'b0, 32'd0, 1'b1};
        tab_a[4]  = '{7,  8'h00, 2'd3, 32'd6, 1'b0, 32'd0, 1'b1};
        tab_a[5]  = '{10, 8'h00, 2'd3, 32'd9, 1'b1, 32'd0, 1'b1};
        tab_a[6]  = '{11, 8'h00, 2'd3, 32'd0, 1'b0, 32'd1, 1'b1};
        tab_a[7]  = '{14, 8'h01, 2'd3, 32'd3, 1'b0, 32'd1, 1'b1};
        tab_a[8]  = '{16, 8'h01, 2'd3, 32'd5, 1'b0, 32'd1, 1'b1};
        tab_a[9]  = '{17, 8'h00, 2'd3, 32'd6, 1'b0, 32'd1, 1'b1};
        tab_a[10] = '{20, 8'h00, 2'd3, 32'd9, 1'b1, 32'd1, 1'b1};
        tab_a[11] = '{21, 8'h00, 2'd1, 32'd0, 1'b0, 32'd0, 1'b0};
        // Infinite burst, ch0 window (7,3) wraps past frame end, ch1 inverted idle.
        tab_c[0]  = '{1,  8'h02, 2'd3, 32'd0, 1'b0, 32'd0, 1'b1};
        tab_c[1]  = '{8,  8'h02, 2'd3, 32'd7, 1'b0, 32'd0, 1'b1};
        tab_c[2]  = '{9,  8'h03, 2'd3, 32'd8, 1'b0, 32'd0, 1'b1};
        tab_c[3]  = '{10, 8'h03, 2'd3, 32'd9, 1'b1, 32'd0, 1'b1};
        tab_c[4]  = '{11, 8'h02, 2'd3, 32'd0, 1'b0, 32'd1, 1'b1};
        tab_c[5]  = '{19, 8'h03, 2'd3, 32'd8, 1'b0, 32'd1, 1'b1};
        tab_c[6]  = '{20, 8'h03, 2'd3, 32'd9, 1'b1, 32'd1, 1'b1};
        tab_c[7]  = '{21, 8'h02, 2'd3, 32'd0, 1'b0, 32'd2, 1'b1};

        rst = 1'b1; enable = 1'b0; sync = 1'b0;
        burst_count = '0; startup_delay = '0; frame_length = 32'd10;
        ch_en = '0; ch_pol = '0; win_on = '0; win_off = '0;
        tick(); tick();
        check("rst_state", 32'(state), 32'd0);
        check("rst_channel", 32'(channel), 32'hA5);
        check("rst_counter", counter, 32'd0);
        check("rst_active", 32'(active), 32'd0);
        check("rst_eof", 32'(endof_frame), 32'd0);
        check("rst_fidx", frame_index, 32'd0);

        rst = 1'b0; enable = 1'b1;
        tick();
        check("armed_state", 32'(state), 32'd1);
        check("armed_channel_default", 32'(channel), 32'hA5);

        // Scenario A
        burst_count = 32'd2; startup_delay = '0; frame_length = 32'd10;
        ch_en = 8'h01; ch_pol = 8'h00;
        set_win(0, 0, 32'd2, 32'd5);
        set_win(0, 1, 32'd0, 32'd0);
        start_sync();
        for (int i = 0; i < 12; i++) run_vec("a", tab_a[i]);

        // Startup delay of 4, single frame burst
        burst_count = 32'd1; startup_delay = 32'd4; ch_en = 8'h00;
        start_sync();
        check("b_k1_state", 32'(state), 32'd2);
        check("b_k1_active", 32'(active), 32'd1);
        check("b_k1_counter", counter, 32'd0);
        repeat (3) tick();
        check("b_k4_state", 32'(state), 32'd2);
        check("b_k4_counter", counter, 32'd3);
        tick();
        check("b_k5_state", 32'(state), 32'd3);
        check("b_k5_counter", counter, 32'd0);
        repeat (10) tick();
        check("b_k15_state", 32'(state), 32'd1);

        // frame_length 0 behaves as 1: every cycle ends a frame
        burst_count = 32'd3; startup_delay = '0; frame_length = '0;
        start_sync();
        check("d_k1_eof", 32'(endof_frame), 32'd1);
        check("d_k1_fidx", frame_index, 32'd0);
        tick();
        check("d_k2_fidx", frame_index, 32'd1);
        tick();
        check("d_k3_fidx", frame_index, 32'd2);
        check("d_k3_eof", 32'(endof_frame), 32'd1);
        tick();
        check("d_k4_state", 32'(state), 32'd1);

        // Scenario C; frame_length change after capture must not matter
        burst_count = '0; startup_delay = '0; frame_length = 32'd10;
        ch_en = 8'h03; ch_pol = 8'h02;
        set_win(0, 0, 32'd7, 32'd3);
        start_sync();
        frame_length = 32'd20;
        for (int i = 0; i < 8; i++) run_vec("c", tab_c[i]);
        repeat (6) tick();
        check("c_k27_counter", counter, 32'd6);
        sync = 1'b1;
        tick();
        sync = 1'b0;
`ifdef TDD_MULTIWIN_RESYNC_EN
        check("resync_counter", counter, 32'd0);
        check("resync_fidx", frame_index, 32'd0);
        check("resync_state", 32'(state), 32'd3);
`else
        check("resync_counter", counter, 32'd7);
        check("resync_fidx", frame_index, 32'd2);
        check("resync_state", 32'(state), 32'd3);
`endif

        // Disable coincident with sync while running
        tick();
        enable = 1'b0; sync = 1'b1;
        tick();
        sync = 1'b0;
        check("dis_run_state", 32'(state), 32'd0);
        check("dis_run_channel", 32'(channel), 32'h02);
        check("dis_run_active", 32'(active), 32'd0);
        check("dis_run_counter", counter, 32'd0);
        check("dis_run_fidx", frame_index, 32'd0);
        enable = 1'b1;
        tick();
        check("rearm_state", 32'(state), 32'd1);
        enable = 1'b0; sync = 1'b1;
        tick();
        sync = 1'b0;
        check("dis_armed_state", 32'(state), 32'd0);
        check("dis_armed_active", 32'(active), 32'd0);
        enable = 1'b1;
        tick();

        // Async reset mid-frame
        burst_count = '0; startup_delay = '0; frame_length = 32'd10;
        ch_en = 8'h00; ch_pol = 8'hF0;
        start_sync();
        repeat (3) tick();
        check("pre_rst_channel", 32'(channel), 32'hF0);
        check("pre_rst_counter", counter, 32'd3);
        #2 rst = 1'b1;
        #1;
        check("async_rst_state", 32'(state), 32'd0);
        check("async_rst_channel", 32'(channel), 32'hA5);
        check("async_rst_counter", counter, 32'd0);
        check("async_rst_active", 32'(active), 32'd0);
        tick();
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
